// File: rtl/logic_cmd_pkg.sv
// Shared types for the logic command sequencer: opcode encoding and the
// queued command record.
package logic_cmd_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_OR  = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } opcode_t;

  typedef struct packed {
    opcode_t          opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational 4-function logic unit evaluated on the FIFO head.
module logic_op_core
  import logic_cmd_pkg::*;
#(
  parameter int WIDTH = logic_cmd_pkg::WIDTH
) (
  input  logic [1:0]       i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  // opcode decode; b is a don't-care for NOT
  always_comb begin
    o_y = '0;
    case (i_opcode)
      OP_NOT:  o_y = ~i_a;
      OP_OR:   o_y = i_a | i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/logic_cmd_sequencer.sv
// Command FIFO in front of the logic core with a registered, backpressured
// result port. Full/empty come from the occupancy counter, not pointer compare.
module logic_cmd_sequencer
  import logic_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = logic_cmd_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_opcode,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [1:0]               res_opcode,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               issued_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [1:0]       r_mem_op [DEPTH];
  logic [WIDTH-1:0] r_mem_a  [DEPTH];
  logic [WIDTH-1:0] r_mem_b  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [1:0]       r_res_opcode;
  logic [7:0]       r_issued;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head_y;

  // cmd_ready sees only the registered level, so a same-cycle pop at full
  // never lets a push in
  assign w_push = cmd_valid && (r_level != LVL_FULL);
  assign w_pop  = (r_level != LVL_W'(0)) && (!r_res_valid || res_ready);

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .i_opcode (r_mem_op[r_rd_ptr]),
    .i_a      (r_mem_a[r_rd_ptr]),
    .i_b      (r_mem_b[r_rd_ptr]),
    .o_y      (w_head_y)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr] <= cmd_opcode;
      r_mem_a[r_wr_ptr]  <= cmd_a;
      r_mem_b[r_wr_ptr]  <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // result register: load on pop, otherwise drain on handshake and hold data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_opcode <= 2'b00;
      r_issued     <= 8'd0;
    end else if (w_pop) begin
      r_res_valid  <= 1'b1;
      r_res_data   <= w_head_y;
      r_res_opcode <= r_mem_op[r_rd_ptr];
      r_issued     <= r_issued + 8'd1;
    end else if (res_ready) begin
      r_res_valid  <= 1'b0;
    end
  end

  assign cmd_ready    = (r_level != LVL_FULL);
  assign level        = r_level;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_opcode   = r_res_opcode;
  assign issued_count = r_issued;

endmodule

// File: doc/logic_cmd_sequencer.md
# logic_cmd_sequencer

Buffered command front-end for the 4-bit logic unit: accepts {opcode, a, b} commands over a valid/ready handshake, queues them in a small FIFO, evaluates each command in order through a combinational logic core, and presents registered results on a valid/ready output port with full backpressure. It sits between a command producer (controller or testbench driver) and any result consumer, decoupling their rates.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- WIDTH, 4, operand/result width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (= not full)
- cmd_opcode  in  2  00 NOT a, 01 a OR b, 10 a AND b, 11 a XOR b
- cmd_a  in  WIDTH  operand a
- cmd_b  in  WIDTH  operand b (ignored for NOT)
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer takes result
- res_data  out  WIDTH  result
- res_opcode  out  2  opcode that produced res_data
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- issued_count  out  8  results produced since reset, wraps 255→0

## Operation
- Push: cmd_valid && cmd_ready writes {opcode,a,b} at wr_ptr, wr_ptr++ (mod DEPTH).
- cmd_ready = (level != DEPTH); depends only on registered level, never on res_ready or pop.
- Pop: fifo non-empty && (!res_valid || res_ready). On pop, head entry evaluated by logic core, result + opcode loaded into res_data/res_opcode, res_valid=1, rd_ptr++, issued_count++.
- Transfer without pop (res_valid && res_ready && empty): res_valid→0; res_data/res_opcode hold last value.
- Result register never overwritten while res_valid && !res_ready.
- Level: +1 push only, −1 pop only, unchanged on simultaneous push+pop or neither.
- Full: cmd_ready=0; a same-cycle pop does not enable a push that cycle.
- Empty: no pop; res_valid drops after its handshake.
- Commands complete strictly in acceptance order; none dropped or duplicated.
- Pointer wrap: rd/wr pointers wrap modulo DEPTH; full/empty from level, not pointer compare.

## Timing
- Reset (async assert, sync-safe deassert): level=0, pointers=0, res_valid=0, res_data=0, res_opcode=00, issued_count=0; cmd_ready=1. FIFO contents need not be cleared.
- Reset mid-operation discards all queued commands and any pending result.
- Latency: command accepted at edge N into an empty FIFO with res_valid=0 appears with res_valid=1 after edge N+1 (one cycle).
- Throughput: one result per cycle sustained when res_ready held high and cmd_valid held high.
- No combinational path from cmd_* to res_* or from res_ready to cmd_ready.

## Structure
- Package logic_cmd_pkg: opcode enum (OP_NOT=2'b00, OP_OR=2'b01, OP_AND=2'b10, OP_XOR=2'b11), cmd_t struct {opcode, a, b}, WIDTH default.
- Sub-module logic_op_core: purely combinational opcode/a/b → y, instantiated once on the FIFO head; the FIFO storage, pointers, level and result register stay in logic_cmd_sequencer.

## Test plan
- Single op: after reset push {01, 4'b1010, 4'b0101} with res_ready=1 → next cycle res_valid=1, res_data=4'b1111, res_opcode=01, issued_count=1.
- All opcodes: push NOT 4'h3, OR 4'hC/4'h1, AND 4'hC/4'hA, XOR 4'hF/4'h5 back-to-back → results 4'hC, 4'hD, 4'h8, 4'hA in order, one per cycle.
- Backpressure/full: res_ready=0, push 5 commands → first goes to result register, next 4 fill FIFO (level=4, cmd_ready=0); 6th cmd_valid not accepted; release res_ready → all 5 results drain in order.
- Simultaneous push+pop at full: level=4, res_ready=1, cmd_valid=1 → that cycle no push, level goes 4→3, cmd_ready=1 next cycle.
- Wrap: stream 20 commands with random res_ready stalls → scoreboard matches all 20, pointers wrapped ≥ 4 times, issued_count=20.
- Reset mid-stream: level=3, res_valid=1, assert rst_n=0 → immediately res_valid=0, level=0, issued_count=0; after release no stale results appear.
